// File: rtl/yarp_wb_unit_if.sv
// Producer and register-file write-port bundle for the yarp writeback unit.
// The unit connects as slave; producers and the register-file side connect as master.
interface yarp_wb_unit_if;
   logic        alu_valid_i;
   logic        alu_ready_o;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        lsu_valid_i;
   logic        lsu_ready_o;
   logic [4:0]  lsu_rd_i;
   logic [31:0] lsu_data_i;
   logic [1:0]  lsu_size_i;
   logic        lsu_zero_ext_i;
   logic [1:0]  lsu_byte_off_i;
   logic [4:0]  rd_addr_o;
   logic        wr_en_o;
   logic [31:0] wr_data_o;
   logic        busy_o;

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_size_i, lsu_zero_ext_i, lsu_byte_off_i,
      input  alu_ready_o, lsu_ready_o,
      input  rd_addr_o, wr_en_o, wr_data_o, busy_o
   );

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  lsu_valid_i, lsu_rd_i, lsu_data_i, lsu_size_i, lsu_zero_ext_i, lsu_byte_off_i,
      output alu_ready_o, lsu_ready_o,
      output rd_addr_o, wr_en_o, wr_data_o, busy_o
   );
endinterface

// File: rtl/yarp_wb_unit.sv
// Writeback unit: per-producer result queues, load lane extraction/extension,
// starvation-bounded arbitration and a registered register-file write port.

module yarp_wb_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 37
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];
   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
endmodule

module yarp_wb_unit #(
   parameter int unsigned DEPTH        = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic           clk,
   input logic           reset_n,
   yarp_wb_unit_if.slave wb
);
   localparam int unsigned   SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = STARVE_LIMIT[SW-1:0];

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_ALU,
      SEL_LSU
   } sel_e;

   logic        alu_push;
   logic        alu_pop;
   logic        alu_full;
   logic        alu_empty;
   logic [36:0] alu_head;
   logic        lsu_push;
   logic        lsu_pop;
   logic        lsu_full;
   logic        lsu_empty;
   logic [36:0] lsu_head;
   logic [31:0] lsu_ext;

   sel_e          sel;
   logic [SW-1:0] starve_cnt;
   logic [SW-1:0] starve_nxt;
   logic [4:0]    pop_rd;
   logic [31:0]   pop_data;

   logic          wr_en_q;
   logic [4:0]    rd_q;
   logic [31:0]   wr_data_q;

   function automatic logic [31:0] lsu_extend(
      input logic [31:0] word,
      input logic [1:0]  size,
      input logic        zext,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         2'd0:    lsu_extend = zext ? {24'h000000, b} : {{24{b[7]}}, b};
         2'd1:    lsu_extend = zext ? {16'h0000, h} : {{16{h[15]}}, h};
         default: lsu_extend = word;
      endcase
   endfunction

   assign wb.alu_ready_o = reset_n & ~alu_full;
   assign wb.lsu_ready_o = reset_n & ~lsu_full;
   assign alu_push       = wb.alu_valid_i & wb.alu_ready_o;
   assign lsu_push       = wb.lsu_valid_i & wb.lsu_ready_o;

   // Loads are stored already extended, so the pop path is identical for both queues.
   assign lsu_ext = lsu_extend(wb.lsu_data_i, wb.lsu_size_i, wb.lsu_zero_ext_i, wb.lsu_byte_off_i);

   yarp_wb_fifo #(.DEPTH(DEPTH), .WIDTH(37)) u_alu_q (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (alu_push),
      .push_data ({wb.alu_rd_i, wb.alu_data_i}),
      .pop       (alu_pop),
      .pop_data  (alu_head),
      .full      (alu_full),
      .empty     (alu_empty)
   );

   yarp_wb_fifo #(.DEPTH(DEPTH), .WIDTH(37)) u_lsu_q (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (lsu_push),
      .push_data ({wb.lsu_rd_i, lsu_ext}),
      .pop       (lsu_pop),
      .pop_data  (lsu_head),
      .full      (lsu_full),
      .empty     (lsu_empty)
   );

   // Loads win by default; a starved ALU queue takes one slot at the limit.
   always_comb begin
      sel        = SEL_NONE;
      starve_nxt = '0;
      alu_pop    = 1'b0;
      lsu_pop    = 1'b0;
      pop_rd     = '0;
      pop_data   = '0;
      if (!lsu_empty && !((starve_cnt == STARVE_MAX) && !alu_empty)) begin
         sel = SEL_LSU;
      end else if (!alu_empty) begin
         sel = SEL_ALU;
      end
      if (!alu_empty && (sel != SEL_ALU)) begin
         starve_nxt = (starve_cnt == STARVE_MAX) ? starve_cnt : starve_cnt + 1'b1;
      end
      case (sel)
         SEL_ALU: begin
            alu_pop            = 1'b1;
            {pop_rd, pop_data} = alu_head;
         end
         SEL_LSU: begin
            lsu_pop            = 1'b1;
            {pop_rd, pop_data} = lsu_head;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         starve_cnt <= '0;
         wr_en_q    <= 1'b0;
         rd_q       <= '0;
         wr_data_q  <= '0;
      end else begin
         starve_cnt <= starve_nxt;
         wr_en_q    <= (sel != SEL_NONE) && (pop_rd != 5'd0);
         if (sel != SEL_NONE) begin
            rd_q      <= pop_rd;
            wr_data_q <= pop_data;
         end
      end
   end

   assign wb.rd_addr_o = rd_q;
   assign wb.wr_en_o   = wr_en_q;
   assign wb.wr_data_o = wr_data_q;
   assign wb.busy_o    = !alu_empty || !lsu_empty || wr_en_q;
endmodule

// File: doc/yarp_wb_unit.md
Name: yarp_wb_unit

Overview:
- Writeback unit for the yarp core; sole writer of the register file write port.
- Accepts completed results from two producers: the ALU path and the load/store unit (LSU) load-return path.
- Queues each producer independently, applies load-data lane selection and sign/zero extension, and arbitrates one register write per cycle.
- Suppresses writes to x0.

Parameters:
- DEPTH, 2, entries per producer queue (power of two, >=2).
- STARVE_LIMIT, 4, consecutive lost-arbitration cycles after which the ALU queue wins (>=1).

Ports:
- clk  input  1  core clock
- reset_n  input  1  synchronous active-low reset
- alu_valid_i  input  1  ALU result valid
- alu_ready_o  output  1  ALU queue can accept
- alu_rd_i  input  5  ALU destination register
- alu_data_i  input  32  ALU result
- lsu_valid_i  input  1  load return valid
- lsu_ready_o  output  1  LSU queue can accept
- lsu_rd_i  input  5  load destination register
- lsu_data_i  input  32  raw aligned memory word
- lsu_size_i  input  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
- lsu_zero_ext_i  input  1  1=zero-extend (LBU/LHU), 0=sign-extend
- lsu_byte_off_i  input  2  address[1:0] of the load
- rd_addr_o  output  5  register file write address
- wr_en_o  output  1  register file write enable
- wr_data_o  output  32  register file write data
- busy_o  output  1  any queue non-empty or write in flight

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-low on reset_n.
- Reset:
  - Sampled on a clk rising edge with reset_n=0: both queues empty, starvation counter=0, rd_addr_o=0, wr_en_o=0, wr_data_o=0, busy_o=0.
  - alu_ready_o and lsu_ready_o are 0 while reset_n=0.
  - Reset mid-operation discards all queued entries and any pending write; no write is issued in the cycle following reset.
- Handshake:
  - A transfer occurs when valid_i && ready_o at a rising edge.
  - ready_o = !full of that producer's queue; there is no same-cycle pass-through when full.
  - Producers hold inputs stable while valid_i && !ready_o.
- Queues:
  - Independent FIFOs, DEPTH entries each, pointer wrap at DEPTH.
  - Push and pop in the same cycle on a non-full queue is legal; count is unchanged.
- LSU extension (applied at push; stored value is final):
  - byte: lane = lsu_data_i[8*off+7:8*off], extended to 32 bits.
  - half: lane = lsu_data_i[16*off[1]+15:16*off[1]]; off[0] ignored; extended to 32 bits.
  - word/reserved: lsu_data_i unchanged; off ignored.
- Arbitration (one pop per cycle):
  - LSU queue non-empty -> pop LSU, except when starve_cnt == STARVE_LIMIT and the ALU queue is non-empty -> pop ALU.
  - LSU empty -> pop ALU if non-empty.
  - starve_cnt increments (saturating at STARVE_LIMIT) when the ALU queue is non-empty and loses; it clears when ALU pops or the ALU queue is empty.
- Write port:
  - Registered; an entry popped in cycle N drives rd_addr_o/wr_data_o with wr_en_o=1 in cycle N+1.
  - Entries with rd=0 are popped normally, but wr_en_o=0 in N+1 (rd_addr_o and wr_data_o still updated).
  - Minimum latency: accepted at edge N, popped in cycle N+1, written in cycle N+2.
  - wr_en_o=0 in any cycle following a no-pop cycle.
- busy_o = ALU queue non-empty || LSU queue non-empty || wr_en_o.
- Ordering: per-producer FIFO order is preserved; no ordering is guaranteed across producers.

Test Plan:
- Reset, then one ALU push rd=5 data=0xDEADBEEF -> two cycles later wr_en_o=1, rd_addr_o=5, wr_data_o=0xDEADBEEF for exactly one cycle; busy_o falls the cycle after.
- LSU byte loads of data=0x80FF7F01 -> off=3 sign gives 0xFFFFFF80; off=2 zero gives 0x000000FF; half off=2 sign gives 0xFFFF80FF; half off=1 gives 0x00007F01 (lower half); word gives 0x80FF7F01.
- Both producers push every cycle for 12 cycles with STARVE_LIMIT=4 -> write stream is LSU x4, ALU x1, repeating; ALU never goes more than 4 writes without service; per-producer order intact.
- Hold the write side off by continuous LSU traffic until the ALU queue holds DEPTH=2 entries -> alu_ready_o=0, the third ALU beat is held and accepted only after a pop; no data loss or duplication.
- Push ALU rd=0 data=0x1234 -> wr_en_o stays 0 and busy_o returns to 0 after drain.
- Assert reset_n=0 for one cycle with 2 entries queued in each producer -> no write occurs after reset, ready_o=0 during reset and 1 after, busy_o=0.
